timer_seq: RTL

TIMER_SEQ -- requirements
Module: timer_seq

---
 rtl/timer_seq_pkg.sv | 34 +++
 rtl/timer_seq_if.sv | 57 +++++
 rtl/timer_seq_fifo.sv | 83 ++++++++
 rtl/timer_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_seq_pkg.sv
//==============================================================================
//  Module   : timer_seq_pkg
//  Purpose  : Shared definitions for the timer job sequencer: sequencer FSM
//             state encoding, timer register addresses and the default
//             timer data width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package timer_seq_pkg;

   // Default width of the timer period / PWM / stop-count fields
   localparam int unsigned c_dw_default = 16;

   // Timer register map as seen on oAddr
   localparam logic [1:0] c_addr_max  = 2'd0;
   localparam logic [1:0] c_addr_pwm  = 2'd1;
   localparam logic [1:0] c_addr_stop = 2'd2;

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_MAX  = 3'd1,
      S_WR_PWM  = 3'd2,
      S_WR_STOP = 3'd3,
      S_START   = 3'd4,
      S_WAIT_HI = 3'd5,
      S_WAIT_LO = 3'd6
   } state_t;

endpackage : timer_seq_pkg

`default_nettype wire

// File: rtl/timer_seq_if.sv
//==============================================================================
//  Module   : timer_seq_if
//  Purpose  : Bundles the job-submission handshake, the timer register-write
//             bus and the status outputs of timer_seq.
//  Ports    : slave modport  - used by timer_seq
//             master modport - used by whoever feeds jobs / models the timer
//             iJob_Valid/iJob_Max/iJob_Pwm/iJob_Stop/oJob_Ready : job offer
//             oAddr/oWe/oStart/oWdata/iTimer_End               : timer side
//             oBusy/oDone/oLevel                               : status
//             oErr (only with TIMER_SEQ_TIMEOUT_EN defined)     : watchdog
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface timer_seq_if
   import timer_seq_pkg::*;
#(
   parameter int unsigned DW    = c_dw_default,
   parameter int unsigned DEPTH = 4
);

   logic                     iJob_Valid;
   logic [DW-1:0]            iJob_Max;
   logic [DW-1:0]            iJob_Pwm;
   logic [DW-1:0]            iJob_Stop;
   logic                     oJob_Ready;
   logic [1:0]               oAddr;
   logic                     oWe;
   logic                     oStart;
   logic [DW-1:0]            oWdata;
   logic                     iTimer_End;
   logic                     oBusy;
   logic                     oDone;
   logic [$clog2(DEPTH):0]   oLevel;
`ifdef TIMER_SEQ_TIMEOUT_EN
   logic                     oErr;
`endif

   modport slave (
`ifdef TIMER_SEQ_TIMEOUT_EN
      output oErr,
`endif
      input  iJob_Valid, iJob_Max, iJob_Pwm, iJob_Stop, iTimer_End,
      output oJob_Ready, oAddr, oWe, oStart, oWdata, oBusy, oDone, oLevel
   );

   modport master (
`ifdef TIMER_SEQ_TIMEOUT_EN
      input  oErr,
`endif
      output iJob_Valid, iJob_Max, iJob_Pwm, iJob_Stop, iTimer_End,
      input  oJob_Ready, oAddr, oWe, oStart, oWdata, oBusy, oDone, oLevel
   );

endinterface : timer_seq_if

`default_nettype wire

// File: rtl/timer_seq_fifo.sv
//==============================================================================
//  Module   : timer_seq_fifo
//  Purpose  : Synchronous first-word-fall-through job FIFO with registered
//             full/empty flags and an occupancy count.
//  Ports    : iCLK, iRSTn           - clock, async active-low reset
//             iPush, iPush_Data     - write request/data (ignored when full)
//             iPop, oPop_Data       - read request / head entry
//             oFull, oEmpty, oLevel - registered status
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_seq_fifo #(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 4
) (
   input  wire logic                     iCLK,
   input  wire logic                     iRSTn,
   input  wire logic                     iPush,
   input  wire logic [WIDTH-1:0]         iPush_Data,
   input  wire logic                     iPop,
   output logic      [WIDTH-1:0]         oPop_Data,
   output logic                          oFull,
   output logic                          oEmpty,
   output logic      [$clog2(DEPTH):0]   oLevel
);

   localparam int unsigned c_aw = $clog2(DEPTH);
   // DEPTH is a power of two, so the full count is just the top level bit
   localparam logic [c_aw:0] c_full_lvl = {1'b1, {c_aw{1'b0}}};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_level;
   logic             r_full;
   logic             r_empty;
   logic [c_aw:0]    w_level_nxt;
   logic             w_push;
   logic             w_pop;

   assign w_push = iPush & ~r_full;
   assign w_pop  = iPop  & ~r_empty;

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + 1'b1;
         2'b01:   w_level_nxt = r_level - 1'b1;
         default: w_level_nxt = r_level;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == c_full_lvl);
         r_empty <= (w_level_nxt == '0);
      end
   end

   // Storage needs no reset: the flags alone decide what is valid
   always_ff @(posedge iCLK) begin
      if (w_push) r_mem[r_wr_ptr] <= iPush_Data;
   end

   assign oPop_Data = r_mem[r_rd_ptr];
   assign oFull     = r_full;
   assign oEmpty    = r_empty;
   assign oLevel    = r_level;

endmodule : timer_seq_fifo

`default_nettype wire

// File: rtl/timer_seq.sv
//==============================================================================
//  Module   : timer_seq
//  Purpose  : Queues timer jobs {period, PWM threshold, stop count} and plays
//             each one into a timer peripheral: three register writes, a
//             start pulse, then waits for the timer's end window to open and
//             close before reporting completion.
//  Ports    : iCLK   - clock, all logic on the rising edge
//             iRSTn  - asynchronous active-low reset
//             bus    - timer_seq_if.slave (job handshake, timer write bus,
//                      iTimer_End, oBusy/oDone/oLevel)
//  Config   : TIMER_SEQ_TIMEOUT_EN - adds a 20-bit watchdog over the two wait
//             states; after TMO_CYC cycles the job is abandoned and oErr
//             pulses for one cycle instead of oDone.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_seq
   import timer_seq_pkg::*;
#(
   parameter int unsigned DW      = c_dw_default,
   parameter int unsigned DEPTH   = 4,
   parameter logic [19:0] TMO_CYC = 20'd1048575
) (
   input  wire logic iCLK,
   input  wire logic iRSTn,
   timer_seq_if.slave bus
);

   localparam int unsigned c_lw = $clog2(DEPTH) + 1;

   // FIFO side
   logic [3*DW-1:0] w_head;
   logic            w_full;
   logic            w_empty;
   logic [c_lw-1:0] w_level;
   logic            w_pop;

   // FSM and registered outputs
   state_t          r_state;
   state_t          w_state_nxt;
   logic [DW-1:0]   r_job_pwm;
   logic [DW-1:0]   r_job_stop;
   logic            r_we,    w_we_nxt;
   logic            r_start, w_start_nxt;
   logic [1:0]      r_addr,  w_addr_nxt;
   logic [DW-1:0]   r_wdata, w_wdata_nxt;
   logic            r_busy;
   logic            r_done,  w_done_nxt;

   timer_seq_fifo #(
      .WIDTH (3*DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .iCLK       (iCLK),
      .iRSTn      (iRSTn),
      .iPush      (bus.iJob_Valid),
      .iPush_Data ({bus.iJob_Max, bus.iJob_Pwm, bus.iJob_Stop}),
      .iPop       (w_pop),
      .oPop_Data  (w_head),
      .oFull      (w_full),
      .oEmpty     (w_empty),
      .oLevel     (w_level)
   );

`ifdef TIMER_SEQ_TIMEOUT_EN
   localparam logic [19:0] c_tmo_last = TMO_CYC - 20'd1;

   logic [19:0] r_wdog;
   logic        w_tmo;
   logic        r_err, w_err_nxt;

   assign w_tmo = (r_wdog == c_tmo_last);

   // Restarts on every state change so each wait state gets a full budget
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_wdog <= '0;
      end else if (w_state_nxt != r_state) begin
         r_wdog <= '0;
      end else if (r_state == S_WAIT_HI || r_state == S_WAIT_LO) begin
         r_wdog <= r_wdog + 20'd1;
      end
   end
`endif

   // Next-state and next-output logic. Outputs are computed for the state
   // being entered so the registered strobes line up with that state.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_we_nxt    = 1'b0;
      w_start_nxt = 1'b0;
      w_addr_nxt  = c_addr_max;
      w_wdata_nxt = '0;
      w_done_nxt  = 1'b0;
`ifdef TIMER_SEQ_TIMEOUT_EN
      w_err_nxt   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            // Never start while the previous end window is still open
            if (!w_empty && !bus.iTimer_End) begin
               w_state_nxt = S_WR_MAX;
               w_pop       = 1'b1;
               w_we_nxt    = 1'b1;
               w_addr_nxt  = c_addr_max;
               w_wdata_nxt = w_head[2*DW +: DW];
            end
         end
         S_WR_MAX: begin
            w_state_nxt = S_WR_PWM;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = c_addr_pwm;
            w_wdata_nxt = r_job_pwm;
         end
         S_WR_PWM: begin
            w_state_nxt = S_WR_STOP;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = c_addr_stop;
            w_wdata_nxt = r_job_stop;
         end
         S_WR_STOP: begin
            w_state_nxt = S_START;
            w_start_nxt = 1'b1;
         end
         S_START: begin
            w_state_nxt = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (bus.iTimer_End) begin
               w_state_nxt = S_WAIT_LO;
            end
`ifdef TIMER_SEQ_TIMEOUT_EN
            else if (w_tmo) begin
               w_state_nxt = S_IDLE;
               w_err_nxt   = 1'b1;
            end
`endif
         end
         S_WAIT_LO: begin
            if (!bus.iTimer_End) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
`ifdef TIMER_SEQ_TIMEOUT_EN
            else if (w_tmo) begin
               w_state_nxt = S_IDLE;
               w_err_nxt   = 1'b1;
            end
`endif
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_start <= 1'b0;
         r_addr  <= 2'd0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef TIMER_SEQ_TIMEOUT_EN
         r_err   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_we    <= w_we_nxt;
         r_start <= w_start_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= w_done_nxt;
`ifdef TIMER_SEQ_TIMEOUT_EN
         r_err   <= w_err_nxt;
`endif
      end
   end

   // The period field goes straight from the FIFO head onto the bus at pop
   // time, so only the two later fields need holding.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_job_pwm  <= '0;
         r_job_stop <= '0;
      end else if (w_pop) begin
         r_job_pwm  <= w_head[DW +: DW];
         r_job_stop <= w_head[0 +: DW];
      end
   end

   assign bus.oJob_Ready = ~w_full;
   assign bus.oLevel     = w_level;
   assign bus.oWe        = r_we;
   assign bus.oStart     = r_start;
   assign bus.oAddr      = r_addr;
   assign bus.oWdata     = r_wdata;
   assign bus.oBusy      = r_busy;
   assign bus.oDone      = r_done;
`ifdef TIMER_SEQ_TIMEOUT_EN
   assign bus.oErr       = r_err;
`endif

endmodule : timer_seq

`default_nettype wire
